// File: rtl/seq_datapath_pkg.sv
// Shared types for the handshaked add/subtract sequencer: FSM states and operation codes.
package seq_datapath_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STORE_A = 3'd1,
        STORE_B = 3'd2,
        LOAD    = 3'd3,
        EXEC    = 3'd4,
        WB      = 3'd5,
        DONE    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_ACC  = 2'b11
    } op_t;

endpackage

// File: rtl/seq_datapath_if.sv
// Request/response and debug-port bundle between a requester and seq_datapath.
interface seq_datapath_if
    import seq_datapath_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                start;
    op_t                 op;
    logic [WORDSIZE-1:0] num_a;
    logic [WORDSIZE-1:0] num_b;
    logic [ADDR_W-1:0]   base_addr;
    logic                busy;
    logic                done;
    logic [WORDSIZE-1:0] result;
    logic                carry;
    logic                overflow;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [WORDSIZE-1:0] dbg_data;

    modport master (
        output start, op, num_a, num_b, base_addr, dbg_addr,
        input  busy, done, result, carry, overflow, dbg_data
    );

    modport slave (
        input  start, op, num_a, num_b, base_addr, dbg_addr,
        output busy, done, result, carry, overflow, dbg_data
    );

endinterface

// File: rtl/seq_alu.sv
// Combinational add/subtract unit; carry reports carry-out for additions and
// unsigned borrow for subtractions.
module seq_alu
    import seq_datapath_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] i_x,
    input  logic [WORDSIZE-1:0] i_y,
    input  op_t                 i_op,
    output logic [WORDSIZE-1:0] o_sum,
    output logic                o_carry,
    output logic                o_overflow
);

    logic [WORDSIZE:0] w_ext;

    // Extended-width arithmetic: bit WORDSIZE is the carry or the borrow
    always_comb begin
        w_ext      = '0;
        o_overflow = 1'b0;
        case (i_op)
            OP_ADD, OP_ACC: begin
                w_ext      = {1'b0, i_x} + {1'b0, i_y};
                o_overflow = (i_x[WORDSIZE-1] == i_y[WORDSIZE-1]) &&
                             (w_ext[WORDSIZE-1] != i_x[WORDSIZE-1]);
            end
            OP_SUB: begin
                w_ext      = {1'b0, i_x} - {1'b0, i_y};
                o_overflow = (i_x[WORDSIZE-1] != i_y[WORDSIZE-1]) &&
                             (w_ext[WORDSIZE-1] != i_x[WORDSIZE-1]);
            end
            OP_RSUB: begin
                w_ext      = {1'b0, i_y} - {1'b0, i_x};
                o_overflow = (i_x[WORDSIZE-1] != i_y[WORDSIZE-1]) &&
                             (w_ext[WORDSIZE-1] != i_y[WORDSIZE-1]);
            end
            default: begin
                w_ext      = '0;
                o_overflow = 1'b0;
            end
        endcase
        o_sum   = w_ext[WORDSIZE-1:0];
        o_carry = w_ext[WORDSIZE];
    end

endmodule

// File: rtl/seq_datapath.sv
// Handshaked sequencer: stores two operands to scratch memory, reloads them,
// runs the ALU and writes the result back at base+2, then pulses done.
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 32
) (
    input logic          clk,
    input logic          rst,
    seq_datapath_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t              r_state;
    op_t                 r_op;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_b;
    logic [ADDR_W-1:0]   r_base;
    logic [WORDSIZE-1:0] r_opa;
    logic [WORDSIZE-1:0] r_opb;
    logic [WORDSIZE-1:0] r_result;
    logic                r_carry;
    logic                r_overflow;
    logic                r_busy;
    logic                r_done;
    logic [WORDSIZE-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_addr_b;
    logic [ADDR_W-1:0]   w_addr_r;
    logic [WORDSIZE-1:0] w_x;
    logic [WORDSIZE-1:0] w_y;
    logic [WORDSIZE-1:0] w_sum;
    logic                w_carry;
    logic                w_overflow;

    // Power-of-two depth makes the natural ADDR_W rollover the modulo wrap
    assign w_addr_b = r_base + ADDR_W'(1);
    assign w_addr_r = r_base + ADDR_W'(2);

    // Accumulate feeds the held result in as the first operand; opB is ignored
    assign w_x = (r_op == OP_ACC) ? r_result : r_opa;
    assign w_y = (r_op == OP_ACC) ? r_opa    : r_opb;

    seq_alu #(.WORDSIZE(WORDSIZE)) u_alu (
        .i_x        (w_x),
        .i_y        (w_y),
        .i_op       (r_op),
        .o_sum      (w_sum),
        .o_carry    (w_carry),
        .o_overflow (w_overflow)
    );

    // Scratch memory writes; contents survive reset, and reset blocks a pending write
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (r_state)
                STORE_A: r_mem[r_base]   <= r_a;
                STORE_B: r_mem[w_addr_b] <= r_b;
                WB:      r_mem[w_addr_r] <= r_result;
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_base     <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.num_a;
                        r_b     <= bus.num_b;
                        r_base  <= bus.base_addr;
                        r_busy  <= 1'b1;
                        r_state <= STORE_A;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                STORE_A: r_state <= STORE_B;
                STORE_B: r_state <= LOAD;
                LOAD: begin
                    r_opa   <= r_mem[r_base];
                    r_opb   <= r_mem[w_addr_b];
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result   <= w_sum;
                    r_carry    <= w_carry;
                    r_overflow <= w_overflow;
                    r_state    <= WB;
                end
                WB: begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.dbg_data = r_mem[bus.dbg_addr];

endmodule
